// File: rtl/rsc_frame_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder, generators (7,5) octal, memory 2.
// Emits one frame of K soft symbol pairs plus two trellis-terminating tail pairs.
// A one-deep registered output stage with a valid/ready handshake; the symbol
// generator advances only when that stage is empty or being drained.
module rsc_frame_encoder #(
    parameter int unsigned K   = 16,
    parameter int unsigned W   = 7,
    parameter int unsigned AMP = 31
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [K-1:0]        data_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic signed [W-1:0] sys_o,
    output logic signed [W-1:0] enc_o,
    output logic                tail_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned    CntW    = (K > 1) ? $clog2(K) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(K - 1);
    localparam logic [W-1:0]   SymPos  = W'(AMP);
    localparam logic [W-1:0]   SymNeg  = -SymPos;

    typedef enum logic [1:0] {StIdle, StData, StTail, StDone} state_e;

    state_e          state_q, state_d;
    logic [K-1:0]    data_q, data_d;
    logic            s1_q, s1_d, s2_q, s2_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tcnt_q, tcnt_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    sys_q, sys_d, enc_q, enc_d;
    logic            tail_q, tail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Output stage can take a new symbol when empty or when the sink takes the current one.
    logic load;
    logic u, a, p;

    function automatic logic [W-1:0] map_bit(input logic b);
        return b ? SymNeg : SymPos;
    endfunction

    // Next-state, encoder update and output-stage loading.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        valid_d = valid_q;
        sys_d   = sys_q;
        enc_d   = enc_q;
        tail_d  = tail_q;
        done_d  = 1'b0;
        load    = !valid_q || ready_i;
        u       = 1'b0;
        a       = 1'b0;
        p       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    data_d  = data_i;
                    s1_d    = 1'b0;
                    s2_d    = 1'b0;
                    cnt_d   = '0;
                    tcnt_d  = 1'b0;
                    state_d = StData;
                end
            end
            StData: begin
                // data_q shifts left, so the MSB is always the current bit.
                u = data_q[K-1];
                a = u ^ s1_q ^ s2_q;
                p = a ^ s2_q;
                if (load) begin
                    valid_d = 1'b1;
                    sys_d   = map_bit(u);
                    enc_d   = map_bit(p);
                    tail_d  = 1'b0;
                    s1_d    = a;
                    s2_d    = s1_q;
                    data_d  = data_q << 1;
                    if (cnt_q == LastCnt) begin
                        state_d = StTail;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StTail: begin
                // Input chosen to cancel the feedback, driving the trellis toward state 0.
                u = s1_q ^ s2_q;
                p = s2_q;
                if (load) begin
                    valid_d = 1'b1;
                    sys_d   = map_bit(u);
                    enc_d   = map_bit(p);
                    tail_d  = 1'b1;
                    s1_d    = 1'b0;
                    s2_d    = s1_q;
                    tcnt_d  = 1'b1;
                    if (tcnt_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Wait for the last tail symbol to drain, then pulse done.
                if (load) begin
                    valid_d = 1'b0;
                    sys_d   = '0;
                    enc_d   = '0;
                    tail_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = valid_d || done_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= 1'b0;
            valid_q <= 1'b0;
            sys_q   <= '0;
            enc_q   <= '0;
            tail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            valid_q <= valid_d;
            sys_q   <= sys_d;
            enc_q   <= enc_d;
            tail_q  <= tail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign sys_o   = sys_q;
    assign enc_o   = enc_q;
    assign tail_o  = tail_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Scoreboard bench for rsc_frame_encoder: expected symbols are queued at start and
// popped when the sink accepts a symbol.
module tb_rsc_frame_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data;
    logic        ready;
    logic        valid;
    logic [6:0]  sys, enc;
    logic        tail, busy, done;

    logic        start8;
    logic [7:0]  data8;
    logic        ready8;
    logic        valid8;
    logic [6:0]  sys8, enc8;
    logic        tail8, busy8, done8;

    rsc_frame_encoder dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .data_i  (data),
        .ready_i (ready),
        .valid_o (valid),
        .sys_o   (sys),
        .enc_o   (enc),
        .tail_o  (tail),
        .busy_o  (busy),
        .done_o  (done)
    );

    rsc_frame_encoder #(.K(8), .W(7), .AMP(63)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start8),
        .data_i  (data8),
        .ready_i (ready8),
        .valid_o (valid8),
        .sys_o   (sys8),
        .enc_o   (enc8),
        .tail_o  (tail8),
        .busy_o  (busy8),
        .done_o  (done8)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_start  = 0;
    int          n_stall  = 0;
    int          acc_idx  = 0;
    int          done_edge;
    logic [14:0] exp_q[$];
    logic [14:0] exp_tmp[18];
    logic [6:0]  log_sys[18];
    logic [6:0]  log_enc[18];
    logic [14:0] held;
    logic        stalled = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: (7,5) RSC with two terminating tail symbols.
    function automatic void build(input logic [15:0] d, input int k, input int amp);
        logic s1, s2, u, p, a;
        logic [6:0] pos, neg;
        pos = 7'(amp);
        neg = 7'(0) - pos;
        s1  = 1'b0;
        s2  = 1'b0;
        for (int i = 0; i < k + 2; i++) begin
            if (i < k) begin
                u = d[k-1-i];
                a = u ^ s1 ^ s2;
                p = a ^ s2;
            end else begin
                u = s1 ^ s2;
                p = s2;
                a = 1'b0;
            end
            exp_tmp[i] = {(i >= k), (u ? neg : pos), (p ? neg : pos)};
            s2 = s1;
            s1 = a;
        end
    endfunction

    // Accepted-symbol monitor: compares against the queue and checks stall stability.
    always @(negedge clk) begin
        logic [14:0] cur;
        logic [14:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            cur = {tail, sys, enc};
            if (stalled) check("hold", {valid, cur}, {1'b1, held});
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("sym_count", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sym", cur, e);
                end
                if (acc_idx < 18) begin
                    log_sys[acc_idx] = sys;
                    log_enc[acc_idx] = enc;
                end
                acc_idx++;
            end
            if (valid && !ready) n_stall++;
            stalled = valid && !ready;
            held    = cur;
        end
    end

    // Issues a start, queues the expected frame, checks one-cycle start latency.
    task automatic start_frame(input logic [15:0] d);
        start = 1'b1;
        data  = d;
        step();
        start   = 1'b0;
        data    = 16'hDEAD;
        n_start = cyc;
        n_stall = 0;
        acc_idx = 0;
        build(d, 16, 31);
        for (int i = 0; i < 18; i++) exp_q.push_back(exp_tmp[i]);
        check("lat_n", valid, 0);
        step();
        check("lat_n1", valid, 1);
        check("busy_n1", busy, 1);
    endtask

    task automatic wait_done(input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        ready     = 1'b1;
        done_edge = cyc;
        check("done_seen", seen, 1);
        check("q_drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] par;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] par;
        rst    = 1'b1;
        start  = 1'b0;
        data   = 16'h0;
        ready  = 1'b1;
        start8 = 1'b0;
        data8  = 8'h0;
        ready8 = 1'b1;
        repeat (3) step();
        check("rst_valid", valid, 0);
        check("rst_sys", sys, 0);
        check("rst_enc", enc, 0);
        check("rst_tail", tail, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid8", valid8, 0);
        #3 rst = 1'b0;
        step();

        // All-zero frame.
        start_frame(16'h0000);
        wait_done(1'b0);
        check("z_done_edge", done_edge, n_start + 19);
        check("z_busy_done", busy, 1);
        step();
        check("z_done_pulse", done, 0);
        check("z_busy_end", busy, 0);

        // Impulse frame, also checked against hand-derived constants.
        start_frame(16'h8000);
        wait_done(1'b0);
        check("imp_done_edge", done_edge, n_start + 19);
        for (int i = 0; i < 16; i++) par[15-i] = log_enc[i][6];
        check("imp_parity", par, 16'hEDB6);
        check("imp_tsys0", log_sys[16], 7'h61);
        check("imp_tsys1", log_sys[17], 7'h61);
        check("imp_tenc0", log_enc[16], 7'h1F);
        check("imp_tenc1", log_enc[17], 7'h61);
        check("imp_state", {dut.s1_q, dut.s2_q}, 0);
        step();

        // Backpressure with a pseudo-random ready pattern.
        start_frame(16'hF2CF);
        wait_done(1'b1);
        check("bp_done_edge", done_edge, n_start + 19 + n_stall);
        step();

        // Starts while busy are ignored; a start in the done cycle is accepted.
        start_frame(16'hC3A5);
        repeat (3) step();
        start = 1'b1;
        data  = 16'h1234;
        step();
        start = 1'b0;
        repeat (13) step();
        start = 1'b1;
        data  = 16'h5555;
        step();
        start = 1'b0;
        check("sb_done", done, 1);
        check("sb_done_edge", cyc, n_start + 19);
        start_frame(16'h0F0F);
        wait_done(1'b0);
        check("b2b_done_edge", done_edge, n_start + 19);
        step();

        // Asynchronous reset mid-frame at symbol 7.
        start_frame(16'hA5C3);
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        check("mr_valid", valid, 0);
        check("mr_sys", sys, 0);
        check("mr_enc", enc, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        exp_q.delete();
        repeat (2) step();
        #2 rst = 1'b0;
        repeat (3) begin
            step();
            check("mr_no_done", done, 0);
        end
        start_frame(16'hA5C3);
        wait_done(1'b0);
        check("mr_fresh_edge", done_edge, n_start + 19);
        step();

        // K=8, AMP=63 instance.
        start8 = 1'b1;
        data8  = 8'hB4;
        step();
        start8 = 1'b0;
        build(16'h00B4, 8, 63);
        for (int i = 0; i < 10; i++) begin
            step();
            check("k8_sym", {valid8, tail8, sys8, enc8}, {1'b1, exp_tmp[i]});
            if (i == 0) check("k8_bit1", sys8, 7'h41);
            if (i == 1) check("k8_bit0", sys8, 7'h3F);
        end
        step();
        check("k8_done", done8, 1);
        step();
        check("k8_idle", {busy8, valid8, done8}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
